// File: rtl/spwm_deadtime_3ph_pkg.sv
// spwm_deadtime_3ph_pkg: leg state encoding and shared defaults for the dead-time inserter
package spwm_deadtime_3ph_pkg;
  localparam int DT_BITS_DEF = 8;
  typedef logic [1:0] leg_state_t;
  localparam leg_state_t IDLE  = 2'd0;
  localparam leg_state_t DEAD  = 2'd1;
  localparam leg_state_t HS_ON = 2'd2;
  localparam leg_state_t LS_ON = 2'd3;
endpackage

// File: rtl/spwm_deadtime_3ph_leg.sv
// deadtime_leg: one inverter leg; registers its PWM input and turns it into a
// complementary gate pair with a both-off interval on every transition
module deadtime_leg
  import spwm_deadtime_3ph_pkg::*;
#(
  parameter int DT_BITS = DT_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kill,
  input  logic [DT_BITS-1:0] deadtime,
  input  logic               pwm,
  output logic               gate_h,
  output logic               gate_l
);
  localparam logic [DT_BITS-1:0] ONE = DT_BITS'(1);
  logic in_q, tgt, nxt_tgt;
  leg_state_t state, nxt_state;
  logic [DT_BITS-1:0] cnt, nxt_cnt, dt_load;
  assign dt_load = (deadtime == '0) ? ONE : deadtime;
  // every path into DEAD (entry, either ON edge, or a restart) targets the current input
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    nxt_tgt = tgt;
    if (kill) begin
      nxt_state = IDLE;
      nxt_cnt = '0;
    end else if (state == IDLE || (state == HS_ON && !in_q) || (state == LS_ON && in_q) ||
                 (state == DEAD && in_q != tgt)) begin
      nxt_state = DEAD;
      nxt_cnt = dt_load;
      nxt_tgt = in_q;
    end else if (state == DEAD) begin
      nxt_cnt = cnt - ONE;
      nxt_state = (cnt == ONE) ? (tgt ? HS_ON : LS_ON) : DEAD;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      tgt <= 1'b0;
      gate_h <= 1'b0;
      gate_l <= 1'b0;
    end else begin
      in_q <= pwm;
      state <= nxt_state;
      cnt <= nxt_cnt;
      tgt <= nxt_tgt;
      gate_h <= nxt_state == HS_ON;
      gate_l <= nxt_state == LS_ON;
    end
  end
endmodule

// File: rtl/spwm_deadtime_3ph.sv
// spwm_deadtime_3ph: three-phase dead-time inserter with global enable and
// a sticky fault latch that forces every gate off
module spwm_deadtime_3ph
  import spwm_deadtime_3ph_pkg::*;
#(
  parameter int                 DT_BITS    = DT_BITS_DEF,
  parameter logic [DT_BITS-1:0] DT_DEFAULT = DT_BITS'(10)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [DT_BITS-1:0] deadtime,
  input  logic               fault,
  input  logic               fault_clr,
  input  logic               pwm_a,
  input  logic               pwm_b,
  input  logic               pwm_c,
  output logic               gate_ah,
  output logic               gate_al,
  output logic               gate_bh,
  output logic               gate_bl,
  output logic               gate_ch,
  output logic               gate_cl,
  output logic               fault_latched
);
  logic kill;
  // a zero tie-off would silently run at the minimum one-cycle gap
  if (DT_DEFAULT == '0) begin : g_dt_default_check
    $error("DT_DEFAULT must be non-zero");
  end
  // the legs see the latch value from before this edge, so a clear only re-arms them a cycle later
  assign kill = fault_latched | fault | ~enable;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_latched <= 1'b0;
    else fault_latched <= fault | (fault_latched & ~fault_clr);
  end
  deadtime_leg #(.DT_BITS(DT_BITS)) u_leg_a (
    .clk(clk), .rst(rst), .kill(kill), .deadtime(deadtime), .pwm(pwm_a),
    .gate_h(gate_ah), .gate_l(gate_al)
  );
  deadtime_leg #(.DT_BITS(DT_BITS)) u_leg_b (
    .clk(clk), .rst(rst), .kill(kill), .deadtime(deadtime), .pwm(pwm_b),
    .gate_h(gate_bh), .gate_l(gate_bl)
  );
  deadtime_leg #(.DT_BITS(DT_BITS)) u_leg_c (
    .clk(clk), .rst(rst), .kill(kill), .deadtime(deadtime), .pwm(pwm_c),
    .gate_h(gate_ch), .gate_l(gate_cl)
  );
endmodule

// File: tb/tb_spwm_deadtime_3ph.sv
// tb_spwm_deadtime_3ph: directed and random checks of the three-phase dead-time inserter
// against a history-window model of when each gate is allowed to be on
module tb_spwm_deadtime_3ph;
  logic clk = 0, rst = 0, enable = 0, fault = 0, fault_clr = 0;
  logic pwm_a = 0, pwm_b = 0, pwm_c = 0;
  logic [7:0] deadtime = 0;
  logic gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl, fault_latched;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  spwm_deadtime_3ph #(.DT_BITS(8), .DT_DEFAULT(8'd10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .deadtime(deadtime), .fault(fault),
    .fault_clr(fault_clr), .pwm_a(pwm_a), .pwm_b(pwm_b), .pwm_c(pwm_c),
    .gate_ah(gate_ah), .gate_al(gate_al), .gate_bh(gate_bh), .gate_bl(gate_bl),
    .gate_ch(gate_ch), .gate_cl(gate_cl), .fault_latched(fault_latched)
  );

  // A gate for value v is on after edge t exactly when no edge in t-D..t was
  // killed (reset, fault path or disable) and the registered input seen at each
  // of those edges equalled v.
  bit kh[512];
  bit ih[3][512];
  logic [2:0] inq_m = 0;
  logic fl_m = 0;
  logic [5:0] exp_g = 0;
  int n = 0, d, idx;
  bit oh, ol;

  always @(posedge clk or negedge rst) begin
    n++;
    if (!rst) begin
      for (int i = 0; i < 512; i++) kh[i] = 1;
      inq_m = 0;
      fl_m = 0;
      exp_g = 0;
    end else begin
      kh[n % 512] = fl_m | fault | !enable;
      for (int p = 0; p < 3; p++) ih[p][n % 512] = inq_m[p];
      fl_m = fault | (fl_m & !fault_clr);
      d = (deadtime == 0) ? 1 : int'(deadtime);
      for (int p = 0; p < 3; p++) begin
        oh = 1;
        ol = 1;
        for (int j = 0; j <= d; j++) begin
          idx = (n - j + 512) % 512;
          if (kh[idx]) begin oh = 0; ol = 0; end
          if (!ih[p][idx]) oh = 0;
          if (ih[p][idx]) ol = 0;
        end
        exp_g[5 - 2 * p] = oh;
        exp_g[4 - 2 * p] = ol;
      end
      inq_m = {pwm_c, pwm_b, pwm_a};
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [5:0] gates();
    return {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl};
  endfunction

  // advance k falling edges, checking the model on each one
  task automatic cyc(input int k);
    repeat (k) begin
      @(negedge clk);
      chk("model_gates", {2'b0, gates()}, {2'b0, exp_g});
      chk("model_fault_latched", {7'b0, fault_latched}, {7'b0, fl_m});
      chk("no_shoot_through", {5'b0, (gate_ah & gate_al) | (gate_bh & gate_bl) | (gate_ch & gate_cl)}, 8'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) kh[i] = 1;
    cyc(3);
    chk("reset_gates", {2'b0, gates()}, 8'd0);
    chk("reset_fault_latched", {7'b0, fault_latched}, 8'd0);
    // startup with deadtime 4 and phase A high
    rst = 1; enable = 1; deadtime = 4; pwm_a = 1;
    cyc(5);
    chk("t1_ah_still_dead", {7'b0, gate_ah}, 8'd0);
    chk("t1_bl_on", {7'b0, gate_bl}, 8'd1);
    cyc(1);
    chk("t1_ah_on", {7'b0, gate_ah}, 8'd1);
    chk("t1_al_off", {7'b0, gate_al}, 8'd0);
    cyc(8);
    // phase A falls
    pwm_a = 0;
    cyc(1);
    chk("t2_ah_hold", {7'b0, gate_ah}, 8'd1);
    cyc(1);
    chk("t2_ah_off", {6'b0, gate_ah, gate_al}, 8'd0);
    cyc(3);
    chk("t2_al_gap", {7'b0, gate_al}, 8'd0);
    cyc(1);
    chk("t2_al_on", {7'b0, gate_al}, 8'd1);
    cyc(8);
    // 3-cycle pulse on B, narrower than deadtime 5
    deadtime = 5;
    cyc(10);
    pwm_b = 1;
    cyc(2);
    chk("t3_bl_off", {7'b0, gate_bl}, 8'd0);
    cyc(1);
    pwm_b = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("t3_bh_swallowed", {7'b0, gate_bh}, 8'd0);
    end
    chk("t3_bl_gap", {7'b0, gate_bl}, 8'd0);
    cyc(1);
    chk("t3_bl_back", {7'b0, gate_bl}, 8'd1);
    // deadtime 0 behaves as a one-cycle gap
    deadtime = 0;
    cyc(10);
    pwm_c = 1;
    cyc(2);
    chk("t4_c_gap", {6'b0, gate_ch, gate_cl}, 8'd0);
    cyc(1);
    chk("t4_ch_on", {7'b0, gate_ch}, 8'd1);
    // fault latch
    deadtime = 2;
    cyc(5);
    pwm_a = 1; pwm_b = 1;
    cyc(10);
    chk("t5_all_high", {2'b0, gates()}, 8'b0010_1010);
    fault = 1;
    cyc(1);
    chk("t5_gates_off", {2'b0, gates()}, 8'd0);
    chk("t5_fl_set", {7'b0, fault_latched}, 8'd1);
    fault_clr = 1;
    cyc(1);
    chk("t5_fl_hold_both", {7'b0, fault_latched}, 8'd1);
    fault = 0; fault_clr = 0;
    cyc(1);
    chk("t5_fl_sticky", {7'b0, fault_latched}, 8'd1);
    fault_clr = 1;
    cyc(1);
    chk("t5_fl_clear", {7'b0, fault_latched}, 8'd0);
    chk("t5_gates_still_off", {2'b0, gates()}, 8'd0);
    fault_clr = 0;
    cyc(2);
    chk("t5_dead_after_clear", {7'b0, gate_ah}, 8'd0);
    cyc(1);
    chk("t5_resume", {7'b0, gate_ah}, 8'd1);
    // asynchronous reset while legs are on
    cyc(5);
    #2 rst = 0;
    #1 chk("t6_async_on", {1'b0, fault_latched, gates()}, 8'd0);
    cyc(1);
    deadtime = 8;
    rst = 1;
    cyc(12);
    pwm_a = 0;
    cyc(4);
    chk("t6_b_on_before", {7'b0, gate_bh}, 8'd1);
    #2 rst = 0;
    #1 chk("t6_async_dead", {1'b0, fault_latched, gates()}, 8'd0);
    cyc(1);
    rst = 1;
    // random soak; deadtime only changes while disabled
    for (int s = 0; s < 8; s++) begin
      enable = 0;
      cyc(2);
      deadtime = 8'($urandom_range(0, 6));
      enable = 1;
      for (int i = 0; i < 400; i++) begin
        cyc(1);
        if ($urandom_range(0, 5) == 0) pwm_a = ~pwm_a;
        if ($urandom_range(0, 5) == 0) pwm_b = ~pwm_b;
        if ($urandom_range(0, 5) == 0) pwm_c = ~pwm_c;
        fault = ($urandom_range(0, 199) == 0);
        fault_clr = ($urandom_range(0, 29) == 0);
        enable = ($urandom_range(0, 299) != 0);
      end
    end
    fault = 0; fault_clr = 0;
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
